// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state codes, widths and helpers for the PLL lock sequencer.
package pll_lock_sequencer_pkg;

  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;
  localparam int RETRY_W = 8;

  localparam logic [STATE_W-1:0] ST_PLL_RESET   = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK   = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABLE_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN         = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT       = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RESET   = ST_PLL_RESET,
    S_WAIT_LOCK   = ST_WAIT_LOCK,
    S_STABLE_WAIT = ST_STABLE_WAIT,
    S_RUN         = ST_RUN,
    S_FAULT       = ST_FAULT
  } state_e;

  // Loss counter holds at all-ones instead of wrapping back to zero.
  function automatic logic [LOSS_W-1:0] satInc(input logic [LOSS_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Status/control bundle between the lock sequencer and its surroundings.
interface pll_lock_sequencer_if;
  import pll_lock_sequencer_pkg::*;

  logic                pll_locked;
  logic                restart;
  logic                pll_resetb;
  logic                sys_reset_n;
  logic                ready;
  logic                fault;
  logic [STATE_W-1:0]  state;
  logic [LOSS_W-1:0]   loss_count;

  modport master (
    output pll_locked, restart,
    input  pll_resetb, sys_reset_n, ready, fault, state, loss_count
  );

  modport slave (
    input  pll_locked, restart,
    output pll_resetb, sys_reset_n, ready, fault, state, loss_count
  );

endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the reference domain.
module pll_lock_sequencer_sync_2ff (
  input  logic i_clk,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    r_meta <= i_d;
    r_sync <= r_meta;
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Supervises PLL RESETB/LOCK from the reference clock and gates the system reset,
// retrying failed lock attempts and parking in a sticky fault after too many.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int PLL_RST_CYCLES = 12,
  parameter int LOCK_TIMEOUT   = 1200,
  parameter int LOCK_STABLE    = 120,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  pll_lock_sequencer_if.slave  bus
);

  logic w_lk;

  state_e               r_state;
  logic [CNT_W-1:0]     r_timer;
  logic [RETRY_W-1:0]   r_retries;
  logic [LOSS_W-1:0]    r_lossCount;
  logic                 r_pllResetb;
  logic                 r_sysResetN;
  logic                 r_ready;
  logic                 r_fault;

  state_e               w_nextState;
  logic [CNT_W-1:0]     w_nextTimer;
  logic [RETRY_W-1:0]   w_nextRetries;
  logic [LOSS_W-1:0]    w_nextLoss;
  logic                 w_attemptFail;

  pll_lock_sequencer_sync_2ff u_lockSync (
    .i_clk (clock_in),
    .i_d   (bus.pll_locked),
    .o_q   (w_lk)
  );

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state     <= S_PLL_RESET;
      r_timer     <= '0;
      r_retries   <= '0;
      r_lossCount <= '0;
      r_pllResetb <= 1'b0;
      r_sysResetN <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_timer     <= w_nextTimer;
      r_retries   <= w_nextRetries;
      r_lossCount <= w_nextLoss;
      r_pllResetb <= !((w_nextState == S_PLL_RESET) || (w_nextState == S_FAULT));
      r_sysResetN <= (w_nextState == S_RUN);
      r_ready     <= (w_nextState == S_RUN);
      r_fault     <= (w_nextState == S_FAULT);
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextTimer   = r_timer;
    w_nextRetries = r_retries;
    w_nextLoss    = r_lossCount;
    w_attemptFail = 1'b0;

    case (r_state)
      S_PLL_RESET: begin
        if (r_timer == CNT_W'(PLL_RST_CYCLES - 1)) begin
          w_nextState = S_WAIT_LOCK;
          w_nextTimer = '0;
        end else begin
          w_nextTimer = r_timer + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (w_lk) begin
          w_nextState = S_STABLE_WAIT;
          w_nextTimer = '0;
        end else if (r_timer == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_attemptFail = 1'b1;
        end else begin
          w_nextTimer = r_timer + 1'b1;
        end
      end
      S_STABLE_WAIT: begin
        if (!w_lk) begin
          w_attemptFail = 1'b1;
        end else if (r_timer == CNT_W'(LOCK_STABLE - 1)) begin
          w_nextState   = S_RUN;
          w_nextTimer   = '0;
          w_nextRetries = '0;
        end else begin
          w_nextTimer = r_timer + 1'b1;
        end
      end
      S_RUN: begin
        if (!w_lk) begin
          w_nextState = S_PLL_RESET;
          w_nextTimer = '0;
          w_nextLoss  = satInc(r_lossCount);
        end
      end
      S_FAULT: begin
        w_nextState = S_FAULT;
      end
      default: begin
        w_nextState = S_PLL_RESET;
        w_nextTimer = '0;
      end
    endcase

    if (w_attemptFail) begin
      w_nextRetries = r_retries + 1'b1;
      w_nextTimer   = '0;
      w_nextState   = (w_nextRetries == RETRY_W'(MAX_RETRIES)) ? S_FAULT : S_PLL_RESET;
    end

    // Restart overrides the transition but a loss detected this cycle is still counted.
    if (bus.restart) begin
      w_nextState   = S_PLL_RESET;
      w_nextTimer   = '0;
      w_nextRetries = '0;
    end
  end

  assign bus.pll_resetb  = r_pllResetb;
  assign bus.sys_reset_n = r_sysResetN;
  assign bus.ready       = r_ready;
  assign bus.fault       = r_fault;
  assign bus.state       = r_state;
  assign bus.loss_count  = r_lossCount;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and randomized bench for pll_lock_sequencer against a phase/dwell reference model.
module tb_pll_lock_sequencer;

  localparam int RST_CYC = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 5;
  localparam int RETRIES = 3;

  localparam int C_PLL_UP   = 0;
  localparam int C_READY    = 1;
  localparam int C_FAULT    = 2;
  localparam int C_SYS_HELD = 3;
  localparam int C_STABLE   = 4;
  localparam int C_WAITING  = 5;
  localparam int C_RESETING = 6;

  logic clock_in = 1'b0;
  logic resetNIn = 1'b0;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .CNT_W          (16),
    .PLL_RST_CYCLES (RST_CYC),
    .LOCK_TIMEOUT   (TIMEOUT),
    .LOCK_STABLE    (STABLE),
    .MAX_RETRIES    (RETRIES)
  ) dut (
    .clock_in (clock_in),
    .reset_n  (resetNIn),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: phase code, edge on which the phase was entered, failed attempts, losses.
  int mCyc   = 0;
  int mPhase = 0;
  int mEntry = 0;
  int mFails = 0;
  int mLoss  = 0;
  bit mHist1 = 1'b0;
  bit mHist2 = 1'b0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelStep();
    bit lkNow;
    int dwell;
    int nextPhase;
    bit failed;
    lkNow  = mHist2;
    mHist2 = mHist1;
    mHist1 = bus.pll_locked;
    mCyc++;
    if (!resetNIn) begin
      mPhase = 0;
      mEntry = mCyc;
      mFails = 0;
      mLoss  = 0;
    end else begin
      dwell     = mCyc - mEntry;
      nextPhase = mPhase;
      failed    = 1'b0;
      case (mPhase)
        0: if (dwell == RST_CYC) nextPhase = 1;
        1: begin
          if (lkNow) nextPhase = 2;
          else if (dwell == TIMEOUT) failed = 1'b1;
        end
        2: begin
          if (!lkNow) failed = 1'b1;
          else if (dwell == STABLE) begin
            nextPhase = 3;
            mFails    = 0;
          end
        end
        3: begin
          if (!lkNow) begin
            nextPhase = 0;
            mLoss     = (mLoss < 255) ? mLoss + 1 : 255;
          end
        end
        default: nextPhase = mPhase;
      endcase
      if (failed) begin
        mFails++;
        nextPhase = (mFails == RETRIES) ? 4 : 0;
      end
      if (bus.restart) begin
        nextPhase = 0;
        mFails    = 0;
      end
      if (nextPhase != mPhase || failed || bus.restart) mEntry = mCyc;
      mPhase = nextPhase;
    end
  endfunction

  task automatic compareAll();
    checkOutput("state",       int'(bus.state),       mPhase);
    checkOutput("pll_resetb",  int'(bus.pll_resetb),  (mPhase != 0 && mPhase != 4) ? 1 : 0);
    checkOutput("sys_reset_n", int'(bus.sys_reset_n), (mPhase == 3) ? 1 : 0);
    checkOutput("ready",       int'(bus.ready),       (mPhase == 3) ? 1 : 0);
    checkOutput("fault",       int'(bus.fault),       (mPhase == 4) ? 1 : 0);
    checkOutput("loss_count",  int'(bus.loss_count),  mLoss);
  endtask

  task automatic applyStimulus(input bit rstN, input bit rs, input bit lock);
    @(negedge clock_in);
    resetNIn       = rstN;
    bus.restart    = rs;
    bus.pll_locked = lock;
    @(posedge clock_in);
    modelStep();
    #1;
    compareAll();
  endtask

  function automatic bit condMet(input int cond);
    case (cond)
      C_PLL_UP:   return bus.pll_resetb == 1'b1;
      C_READY:    return bus.ready == 1'b1;
      C_FAULT:    return bus.fault == 1'b1;
      C_SYS_HELD: return bus.sys_reset_n == 1'b0;
      C_STABLE:   return bus.state == 3'd2;
      C_WAITING:  return bus.state == 3'd1;
      C_RESETING: return bus.state == 3'd0;
      default:    return 1'b0;
    endcase
  endfunction

  // Ticks with the given lock level until the condition holds; n is the number of edges taken.
  task automatic waitUntil(input string tag, input int cond, input bit lock, input int budget,
                           output int n);
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, lock);
      n++;
    end while (!condMet(cond) && n < budget);
    if (!condMet(cond)) checkOutput({"timeout_", tag}, 0, 1);
  endtask

  initial begin
    int n;
    bit lk;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_state",      int'(bus.state),       0);
    checkOutput("rst_pll_resetb", int'(bus.pll_resetb),  0);
    checkOutput("rst_sys_reset",  int'(bus.sys_reset_n), 0);
    checkOutput("rst_loss",       int'(bus.loss_count),  0);

    waitUntil("first_release", C_PLL_UP, 1'b0, 50, n);
    checkOutput("pll_rst_len", n, RST_CYC);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    waitUntil("first_run", C_READY, 1'b1, 50, n);
    checkOutput("lock_to_ready", n, 2 + STABLE + 1);
    checkOutput("run_state", int'(bus.state), 3);

    applyStimulus(1'b1, 1'b0, 1'b0);
    waitUntil("loss_drop", C_SYS_HELD, 1'b1, 10, n);
    checkOutput("loss_latency", n, 2);
    checkOutput("loss_count1", int'(bus.loss_count), 1);
    waitUntil("loss_rearm", C_PLL_UP, 1'b1, 20, n);
    checkOutput("rearm_len", n, RST_CYC);
    waitUntil("loss_relock", C_READY, 1'b1, 40, n);
    checkOutput("relock_len", n, STABLE + 1);

    applyStimulus(1'b1, 1'b0, 1'b0);
    waitUntil("to_fault", C_FAULT, 1'b0, 200, n);
    checkOutput("fault_len", n, 2 + RETRIES * (RST_CYC + TIMEOUT));
    checkOutput("fault_state", int'(bus.state), 4);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("fault_pll_held", int'(bus.pll_resetb), 0);

    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("restart_fault", int'(bus.fault), 0);
    checkOutput("restart_state", int'(bus.state), 0);
    waitUntil("restart_run", C_READY, 1'b1, 60, n);
    checkOutput("restart_loss_kept", int'(bus.loss_count), 2);

    for (int round = 0; round < 2; round++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
        waitUntil("to_stable", C_STABLE, 1'b1, 40, n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil("stable_fail", C_RESETING, 1'b1, 10, n);
        checkOutput("stable_fail_len", n, 2);
      end
      checkOutput("still_retrying", int'(bus.fault), 0);
      waitUntil("clean_lock", C_READY, 1'b1, 60, n);
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitUntil("sat_drop", C_SYS_HELD, 1'b1, 10, n);
      waitUntil("sat_relock", C_READY, 1'b1, 40, n);
    end
    checkOutput("loss_saturated", int'(bus.loss_count), 255);

    applyStimulus(1'b1, 1'b1, 1'b0);
    waitUntil("to_wait", C_WAITING, 1'b0, 20, n);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midwait_state", int'(bus.state),       0);
    checkOutput("midwait_pll",   int'(bus.pll_resetb),  0);
    checkOutput("midwait_sys",   int'(bus.sys_reset_n), 0);
    checkOutput("midwait_ready", int'(bus.ready),       0);
    checkOutput("midwait_fault", int'(bus.fault),       0);
    checkOutput("midwait_loss",  int'(bus.loss_count),  0);

    // Lock rises readily and drops rarely, so random runs reach RUN, lose lock and sometimes fault.
    lk = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (lk) begin
        if ($urandom_range(39) == 0) lk = 1'b0;
      end else begin
        if ($urandom_range(7) == 0) lk = 1'b1;
      end
      applyStimulus(($urandom_range(499) != 0), ($urandom_range(199) == 0), lk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
